// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the arbiter and the UART transmitter.
// The arbiter takes the slave side; requesters and the transmitter drive the master side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_data_en;
  logic [7:0]           tx_data;
  logic                 txd_valid;

  modport master (
    output req_valid, req_data, txd_valid,
    input  req_ready, tx_data_en, tx_data
  );

  modport slave (
    input  req_valid, req_data, txd_valid,
    output req_ready, tx_data_en, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// pacing the transmitter's level-sensitive enable around each full frame.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 32,
  parameter int START_TO   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout
);
  localparam int PW   = $clog2(NUM_REQ);
  localparam int CMAX = (GAP_CYCLES > START_TO) ? GAP_CYCLES : START_TO;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] START_LAST = CW'(START_TO - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t             state, state_d;
  logic [PW-1:0]      ptr, ptr_d;
  logic [PW-1:0]      winner, grant_d;
  logic [PW:0]        idx;
  logic               found;
  logic [CW-1:0]      cnt, cnt_d;
  logic [NUM_REQ-1:0] ready_d;
  logic               en_d, err_d;
  logic [7:0]         data_d;
  logic [7:0]         req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = bus.req_data[8*g +: 8];
  end

  // First valid requester scanning ptr, ptr+1, ... with wrap at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!found && bus.req_valid[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    ready_d = '0;
    en_d    = bus.tx_data_en;
    err_d   = 1'b0;
    data_d  = bus.tx_data;
    grant_d = grant_id;
    unique case (state)
      IDLE: begin
        en_d = 1'b0;
        if (found) begin
          ready_d[winner] = 1'b1;
          data_d          = req_bytes[winner];
          grant_d         = winner;
          ptr_d           = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          cnt_d           = '0;
          state_d         = START;
        end
      end
      START: begin
        // Enable rises on the first START cycle; the timeout counts only enabled cycles.
        if (bus.txd_valid) begin
          en_d    = 1'b0;
          state_d = WAIT_DONE;
        end else if (!bus.tx_data_en) begin
          en_d = 1'b1;
        end else if (cnt == START_LAST) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        en_d = 1'b0;
        if (!bus.txd_valid) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        en_d = 1'b0;
        if (cnt == GAP_LAST) state_d = IDLE;
        else                 cnt_d   = cnt + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      cnt            <= '0;
      bus.req_ready  <= '0;
      bus.tx_data_en <= 1'b0;
      bus.tx_data    <= '0;
      grant_id       <= '0;
      err_timeout    <= 1'b0;
    end else begin
      state          <= state_d;
      ptr            <= ptr_d;
      cnt            <= cnt_d;
      bus.req_ready  <= ready_d;
      bus.tx_data_en <= en_d;
      bus.tx_data    <= data_d;
      grant_id       <= grant_d;
      err_timeout    <= err_d;
    end
  end

  assign busy = (state != IDLE);
endmodule
